pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: PC_W, 8, program counter width in bits (2..16).
REQ-002 Parameter: PC_MAX, 2, highest legal PC value; wrap boundary (1..2^PC_W-1).
REQ-003 Parameter: DEB_CYC, 16, clk cycles manual_plus must be stable before a level is accepted.
REQ-004 Parameter: TICK_DIV, 50_000_000, clk cycles per auto-step tick (≥2).
REQ-005 Port: clk  input  1  system clock; all state on rising edge except reset.
REQ-006 Port: pc_clr  input  1  reset, asynchronous, active-low.
REQ-007 Port: manual_plus  input  1  raw active-low pushbutton, asynchronous to clk.
REQ-008 Port: run  input  1  1 = auto-step on prescaler tick enabled.
REQ-009 Port: mode  input  2  00 inc, 01 dec, 10 hold, 11 load.
REQ-010 Port: data_in  input  PC_W  load value for mode 11.
REQ-011 Port: PC  output  PC_W  current program counter.
REQ-012 Port: step  output  1  one-cycle pulse on each accepted step event.
REQ-013 Port: wrap  output  1  one-cycle pulse when a step wraps PC_MAX->0 or 0->PC_MAX.
REQ-014 Port: load_err  output  1  one-cycle pulse when a load value exceeds PC_MAX.

Function
REQ-015 manual_plus SHALL pass through a 2-flop synchroniser, then debounce: accepted level changes only after DEB_CYC consecutive identical samples.
REQ-016 A step event SHALL be raised for exactly one cycle on each debounced 1->0 transition of manual_plus; release raises none.
REQ-017 Prescaler SHALL count 0..TICK_DIV-1 while run=1, emit a tick on the terminal count, and reset to 0 whenever run=0.
REQ-018 A step event SHALL also be raised on each tick; manual and tick events in the same cycle SHALL produce a single step.
REQ-019 On a step with mode 00: PC<PC_MAX -> PC+1; PC>=PC_MAX -> 0 and wrap=1.
REQ-020 On a step with mode 01: PC>0 -> PC-1; PC=0 -> PC_MAX and wrap=1.
REQ-021 On a step with mode 10: PC unchanged; step still pulses, wrap=0.
REQ-022 On a step with mode 11: data_in<=PC_MAX -> PC=data_in; otherwise PC=PC_MAX and load_err=1.
REQ-023 PC, step, wrap, load_err SHALL update on the clk edge after the cycle the step event is raised (1-cycle latency); no change without a step event.
REQ-024 If PC ever holds a value >PC_MAX, next inc step SHALL yield 0 with wrap=1, next dec step SHALL yield PC_MAX with wrap=0.
REQ-025 mode and data_in SHALL be sampled only in the cycle the step event is raised.

Reset
REQ-026 pc_clr low SHALL immediately force PC=0, step=0, wrap=0, load_err=0, prescaler=0, synchroniser/debouncer to released (1) state.
REQ-027 A pc_clr assertion mid-debounce or mid-prescale SHALL discard the partial count; no step SHALL be generated by reset deassertion even if manual_plus is held low (debouncer starts released, so a held button produces one step after DEB_CYC cycles).
REQ-028 Reset deassertion SHALL be synchronised internally (2-flop release) before state leaves reset.

Structure
REQ-029 Package pc_pkg SHALL hold the mode encoding constants (MODE_INC, MODE_DEC, MODE_HOLD, MODE_LOAD).
REQ-030 Synchroniser + debouncer + falling-edge detector SHALL be sub-module pc_debounce (parameter DEB_CYC, output one-cycle press pulse).
REQ-031 Prescaler, step arbitration and PC update SHALL reside in pc_sequencer.

Verification
REQ-032 PC_MAX=2, mode=00: 4 clean presses -> PC 1,2,0,1; wrap pulses on press 3 only.
REQ-033 mode=01 from PC=0: one press -> PC=2, wrap=1; next press -> PC=1, wrap=0.
REQ-034 mode=11, data_in=1 -> PC=1, load_err=0; data_in=7 -> PC=2, load_err=1.
REQ-035 Bouncy press (5 toggles each <DEB_CYC cycles, then stable low) -> exactly one step pulse.
REQ-036 run=1, TICK_DIV=4, manual press aligned to tick cycle -> single increment; steps every 4 cycles otherwise.
REQ-037 pc_clr pulsed low mid-count at PC=2, button held -> PC=0 at once, no step at release, one step after DEB_CYC cycles.

Source files
------------

// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program-counter sequencer slice.
//   mode_e        : step-mode encoding driven on the sequencer's mode input
//   SYNC_STAGES   : depth of every clock-domain / reset-release synchroniser
// -----------------------------------------------------------------------------
package pc_pkg;

  // Action taken on each accepted step event.
  typedef enum logic [1:0] {
    MODE_INC  = 2'b00,  // count up, wrap PC_MAX -> 0
    MODE_DEC  = 2'b01,  // count down, wrap 0 -> PC_MAX
    MODE_HOLD = 2'b10,  // keep PC, still pulse step
    MODE_LOAD = 2'b11   // load data_in, clamp to PC_MAX
  } mode_e;

  localparam int SYNC_STAGES = 2;

endpackage : pc_pkg

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Control / status bundle of the program-counter sequencer.
//   run       : enable auto-stepping from the prescaler tick
//   mode      : step action (pc_pkg::mode_e encoding)
//   data_in   : load value used by MODE_LOAD
//   PC        : current program counter
//   step      : one-cycle pulse per accepted step
//   wrap      : one-cycle pulse when a step wraps around the PC range
//   load_err  : one-cycle pulse when a load value was out of range
// master = controller driving the sequencer, slave = the sequencer itself.
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int PC_W = 8
);

  logic            run;
  logic [1:0]      mode;
  logic [PC_W-1:0] data_in;
  logic [PC_W-1:0] PC;
  logic            step;
  logic            wrap;
  logic            load_err;

  modport master (
    output run, mode, data_in,
    input  PC, step, wrap, load_err
  );

  modport slave (
    input  run, mode, data_in,
    output PC, step, wrap, load_err
  );

endinterface : pc_sequencer_if

// File: rtl/pc_debounce.sv
// -----------------------------------------------------------------------------
// pc_debounce
// Conditions the raw active-low manual_plus pushbutton:
// 2-flop synchroniser -> level debouncer -> press (1->0) detector.
// Ports:
//   clk     : system clock
//   pc_clr  : active-low asynchronous reset (already release-synchronised)
//   btn_n   : raw pushbutton, active low, asynchronous to clk
//   press   : one-cycle pulse when the debounced level falls 1 -> 0
// A new level is accepted only after DEB_CYC consecutive synchronised samples
// that all differ from the currently accepted level; any sample matching the
// accepted level restarts the count, which is what rejects contact bounce.
// -----------------------------------------------------------------------------
module pc_debounce
  import pc_pkg::*;
#(
  parameter int DEB_CYC = 16
) (
  input  logic clk,
  input  logic pc_clr,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;
  logic                   level_q;   // accepted (debounced) button level
  logic [CW-1:0]          cnt_q;     // consecutive samples disagreeing with level_q
  logic                   accept;

  assign sample = sync_q[SYNC_STAGES-1];
  assign accept = (sample != level_q) && (cnt_q == DEB_LAST);

  // Synchroniser resets to the released (high) state so a button held through
  // reset is treated as a fresh press once the debounce window has elapsed.
  always_ff @(posedge clk or negedge pc_clr) begin
    if (!pc_clr) begin
      sync_q <= '1;
    end else begin
      // NOTE: non-blocking assignment keeps every flop sampling the value from
      // before the edge, so the shift happens one stage per clock.
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
    end
  end

  always_ff @(posedge clk or negedge pc_clr) begin
    if (!pc_clr) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      press <= accept && !sample;
      if (sample == level_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        level_q <= sample;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule : pc_debounce

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program counter stepped manually (debounced pushbutton) or automatically
// (prescaler tick). Each step applies the action selected by mode.
// Ports:
//   clk          : system clock, all state on the rising edge
//   pc_clr       : asynchronous active-low reset; release is synchronised
//   manual_plus  : raw active-low step pushbutton
//   bus          : pc_sequencer_if.slave (run, mode, data_in in;
//                  PC, step, wrap, load_err out)
// A step event is raised in the cycle a press pulse or a tick occurs (both in
// the same cycle merge into one). mode/data_in are sampled in that cycle and
// PC, step, wrap, load_err are registered on the following edge.
// -----------------------------------------------------------------------------
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int PC_MAX   = 2,
  parameter int DEB_CYC  = 16,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic           clk,
  input  logic           pc_clr,
  input  logic           manual_plus,
  pc_sequencer_if.slave  bus
);

  localparam logic [PC_W-1:0] PC_MAX_V = PC_W'(PC_MAX);
  localparam int              TW       = $clog2(TICK_DIV);
  localparam logic [TW-1:0]   PRE_LAST = TW'(TICK_DIV - 1);

  // ---------------------------------------------------------------------------
  // Reset: assert immediately, release only after SYNC_STAGES clean edges so
  // no flop leaves reset on an edge close to the pc_clr rising transition.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic                   rst_n;

  always_ff @(posedge clk or negedge pc_clr) begin
    if (!pc_clr) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Manual step source
  // ---------------------------------------------------------------------------
  logic press;

  pc_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_debounce (
    .clk    (clk),
    .pc_clr (rst_n),
    .btn_n  (manual_plus),
    .press  (press)
  );

  // ---------------------------------------------------------------------------
  // Auto step source: free-running prescaler held at zero while run is low.
  // ---------------------------------------------------------------------------
  logic [TW-1:0] pre_cnt_q;
  logic          tick;

  assign tick = bus.run && (pre_cnt_q == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else if (!bus.run || tick) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_q + TW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Step arbitration and next-PC computation
  // ---------------------------------------------------------------------------
  logic            step_evt;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_nxt;
  logic            wrap_nxt;
  logic            lerr_nxt;
  mode_e           mode_s;

  // Coincident press and tick collapse into a single event.
  assign step_evt = press | tick;
  assign mode_s   = mode_e'(bus.mode);

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    pc_nxt   = pc_q;
    wrap_nxt = 1'b0;
    lerr_nxt = 1'b0;
    if (step_evt) begin
      case (mode_s)
        MODE_INC: begin
          // Out-of-range PC (> PC_MAX) also restarts at 0 and flags a wrap.
          if (pc_q >= PC_MAX_V) begin
            pc_nxt   = '0;
            wrap_nxt = 1'b1;
          end else begin
            pc_nxt = pc_q + PC_W'(1);
          end
        end
        MODE_DEC: begin
          if (pc_q == '0) begin
            pc_nxt   = PC_MAX_V;
            wrap_nxt = 1'b1;
          end else if (pc_q > PC_MAX_V) begin
            // Recover from an out-of-range PC without reporting a wrap.
            pc_nxt = PC_MAX_V;
          end else begin
            pc_nxt = pc_q - PC_W'(1);
          end
        end
        MODE_HOLD: begin
          pc_nxt = pc_q;
        end
        MODE_LOAD: begin
          if (bus.data_in <= PC_MAX_V) begin
            pc_nxt = bus.data_in;
          end else begin
            pc_nxt   = PC_MAX_V;
            lerr_nxt = 1'b1;
          end
        end
        default: begin
          pc_nxt = pc_q;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  logic step_q;
  logic wrap_q;
  logic lerr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      pc_q   <= pc_nxt;
      step_q <= step_evt;
      wrap_q <= wrap_nxt;
      lerr_q <= lerr_nxt;
    end
  end

  assign bus.PC       = pc_q;
  assign bus.step     = step_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = lerr_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer (PC_MAX=2, DEB_CYC=6, TICK_DIV=4).
// A reference model tracks PC with modular arithmetic over the range
// 0..PC_MAX; a negedge monitor counts step / wrap / load_err pulses.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int PC_W     = 8;
  localparam int PC_MAX   = 2;
  localparam int DEB_CYC  = 6;
  localparam int TICK_DIV = 4;
  localparam int HOLD_CYC = DEB_CYC + 8;

  logic clk;
  logic pc_clr;
  logic manual_plus;

  pc_sequencer_if #(.PC_W(PC_W)) sif ();

  pc_sequencer #(
    .PC_W     (PC_W),
    .PC_MAX   (PC_MAX),
    .DEB_CYC  (DEB_CYC),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk         (clk),
    .pc_clr      (pc_clr),
    .manual_plus (manual_plus),
    .bus         (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor: free-running totals sampled away from the rising edge.
  int cyc           = 0;
  int tot_step      = 0;
  int tot_wrap      = 0;
  int tot_lerr      = 0;
  int last_step_cyc = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sif.step) begin
      tot_step      <= tot_step + 1;
      last_step_cyc <= cyc;
    end
    if (sif.wrap)     tot_wrap <= tot_wrap + 1;
    if (sif.load_err) tot_lerr <= tot_lerr + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;
  int m_pc   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Advance n negedges and settle just after them.
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Reference model: effect of one step on m_pc.
  task automatic model_step(input int m, input int d, output int ew, output int el);
    ew = 0;
    el = 0;
    case (m)
      0: begin ew = (m_pc >= PC_MAX); m_pc = ew ? 0 : m_pc + 1; end
      1: begin ew = (m_pc == 0); m_pc = (m_pc == 0) ? PC_MAX : m_pc - 1; end
      2: ;
      default: begin el = (d > PC_MAX); m_pc = el ? PC_MAX : d; end
    endcase
  endtask

  // One button press (optionally bouncy) and release; expects exactly one step.
  task automatic press(input int m, input int d, input bit bouncy, input string tag);
    int s0, w0, l0, ew, el;
    s0 = tot_step; w0 = tot_wrap; l0 = tot_lerr;
    sif.mode    = m[1:0];
    sif.data_in = d[PC_W-1:0];
    if (bouncy) begin
      for (int i = 0; i < 5; i++) begin
        manual_plus = (i % 2 == 0) ? 1'b0 : 1'b1;
        wait_cyc($urandom_range(1, DEB_CYC - 2));
      end
    end
    manual_plus = 1'b0;
    wait_cyc(HOLD_CYC);
    if (bouncy) begin
      for (int i = 0; i < 4; i++) begin
        manual_plus = (i % 2 == 0) ? 1'b1 : 1'b0;
        wait_cyc($urandom_range(1, DEB_CYC - 2));
      end
    end
    manual_plus = 1'b1;
    wait_cyc(HOLD_CYC);
    model_step(m, d, ew, el);
    check({tag, ".steps"}, tot_step - s0, 1);
    check({tag, ".wrap"},  tot_wrap - w0, ew);
    check({tag, ".lerr"},  tot_lerr - l0, el);
    check({tag, ".pc"},    int'(sif.PC), m_pc);
  endtask

  initial begin
    int s0, ew, el, coincide, sweep0, k;

    pc_clr      = 1'b0;
    manual_plus = 1'b1;
    sif.run     = 1'b0;
    sif.mode    = 2'b00;
    sif.data_in = '0;
    wait_cyc(3);
    check("rst.pc",   int'(sif.PC), 0);
    check("rst.step", int'(sif.step), 0);
    check("rst.wrap", int'(sif.wrap), 0);
    check("rst.lerr", int'(sif.load_err), 0);
    pc_clr = 1'b1;
    wait_cyc(5);
    check("idle.nostep", tot_step, 0);

    // Increment through the wrap boundary.
    for (int i = 0; i < 4; i++) press(0, 0, 1'b0, $sformatf("inc%0d", i));
    // Decrement from 0 wraps to PC_MAX.
    press(3, 0, 1'b0, "load0");
    press(1, 0, 1'b0, "dec0");
    press(1, 0, 1'b0, "dec1");
    // Loads in and out of range.
    press(3, 1, 1'b0, "load1");
    press(3, 7, 1'b0, "load7");
    // Bouncy press and hold.
    press(0, 0, 1'b1, "bouncy");
    press(2, 0, 1'b0, "hold");

    for (int i = 0; i < 16; i++)
      press($urandom_range(0, 3), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
            $sformatf("rnd%0d", i));

    // Auto-stepping: one increment every TICK_DIV cycles.
    sif.mode = 2'b00;
    sif.run  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int prev;
      prev = last_step_cyc;
      s0   = tot_step;
      k    = 0;
      while (tot_step == s0 && k < 2 * TICK_DIV + 2) begin
        wait_cyc(1);
        k++;
      end
      check($sformatf("tick%0d.seen", i), tot_step - s0, 1);
      if (i > 0) check($sformatf("tick%0d.period", i), last_step_cyc - prev, TICK_DIV);
      model_step(0, 0, ew, el);
      check($sformatf("tick%0d.pc", i), int'(sif.PC), m_pc);
    end

    // Press sweep across the four tick phases: in a window of 8*TICK_DIV
    // cycles the ticks give 8 steps; a press adds one unless it lands on a
    // tick cycle, which must happen for exactly one phase.
    coincide = 0;
    sweep0   = tot_step;
    for (int ph = 0; ph < TICK_DIV; ph++) begin
      int n;
      s0 = tot_step;
      k  = 0;
      while (tot_step == s0 && k < 2 * TICK_DIV + 2) begin
        wait_cyc(1);
        k++;
      end
      wait_cyc(ph);
      manual_plus = 1'b0;
      s0 = tot_step;
      wait_cyc(8 * TICK_DIV);
      n = tot_step - s0;
      check($sformatf("phase%0d.count_ok", ph), int'(n == 8 || n == 9), 1);
      if (n == 8) coincide++;
      manual_plus = 1'b1;
      wait_cyc(HOLD_CYC);
    end
    check("phase.coincident", coincide, 1);
    sif.run = 1'b0;
    wait_cyc(2);
    m_pc = (m_pc + (tot_step - sweep0)) % (PC_MAX + 1);
    check("phase.pc", int'(sif.PC), m_pc);
    s0 = tot_step;
    wait_cyc(3 * TICK_DIV);
    check("runoff.nostep", tot_step - s0, 0);
    check("runoff.pc", int'(sif.PC), m_pc);

    // Reset with the button held: PC clears at once, no step on release,
    // then the held button is accepted as one press after the debounce time.
    press(3, 1, 1'b0, "preload");
    sif.mode    = 2'b00;
    manual_plus = 1'b0;
    s0 = tot_step;
    wait_cyc(HOLD_CYC);
    check("held.steps", tot_step - s0, 1);
    model_step(0, 0, ew, el);
    check("held.pc", int'(sif.PC), m_pc);
    wait_cyc(2);
    pc_clr = 1'b0;
    #1;
    m_pc = 0;
    check("clr.pc_now", int'(sif.PC), 0);
    check("clr.step",   int'(sif.step), 0);
    wait_cyc(3);
    pc_clr = 1'b1;
    s0 = tot_step;
    wait_cyc(DEB_CYC);
    check("release.nostep", tot_step - s0, 0);
    wait_cyc(3 * DEB_CYC);
    check("release.onestep", tot_step - s0, 1);
    model_step(0, 0, ew, el);
    check("release.pc", int'(sif.PC), m_pc);
    manual_plus = 1'b1;
    wait_cyc(HOLD_CYC);
    check("final.steps", tot_step - s0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_pc_sequencer
